key_mode_ctrl: RTL

Debounces the active-low user push-button KEY and classifies each press as short or long. It maintains a display/LED pattern mode index for the LCD timing/pattern stage and the RGB LED logic. Short press advances the mode with wrap; long press returns the mode to 0. Sits between the KEY pin and the display pattern stage, entirely in the CLK_SYS (200 MHz) domain.

---
 rtl/key_mode_ctrl_if.sv | 36 +++
 rtl/key_mode_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/key_mode_ctrl_if.sv
// key_mode_ctrl_if: groups the push-button input and the mode/event outputs.
//   KEY          raw button pin, 0 = pressed (driven by master)
//   key_level    debounced key state, 1 = pressed
//   short_press  one-cycle pulse on an accepted short press
//   long_press   one-cycle pulse when the hold time qualifies as long
//   mode         current pattern mode index
//   mode_changed one-cycle pulse whenever a press event writes mode
// Modports: master = board/pattern side, slave = key_mode_ctrl.
interface key_mode_ctrl_if #(
    parameter int unsigned MODE_W = 2
);
    logic              KEY;
    logic              key_level;
    logic              short_press;
    logic              long_press;
    logic [MODE_W-1:0] mode;
    logic              mode_changed;

    modport master (
        output KEY,
        input  key_level,
        input  short_press,
        input  long_press,
        input  mode,
        input  mode_changed
    );

    modport slave (
        input  KEY,
        output key_level,
        output short_press,
        output long_press,
        output mode,
        output mode_changed
    );
endinterface

// File: rtl/key_mode_ctrl.sv
// key_mode_ctrl: debounces the active-low KEY button, classifies each press as
// short or long, and keeps the display/LED pattern mode index.
// Short press advances mode (wrapping at NUM_MODES-1); long press forces mode 0.
// Ports:
//   CLK_SYS  system clock (200 MHz)
//   nRST     asynchronous active-low reset
//   bus      key_mode_ctrl_if.slave: KEY in; key_level, short_press,
//            long_press, mode, mode_changed out (all registered)
module key_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = 4000000,
    parameter int unsigned LONG_CYC     = 200000000,
    parameter int unsigned NUM_MODES    = 4,
    parameter int unsigned MODE_W       = 2
) (
    input  logic           CLK_SYS,
    input  logic           nRST,
    key_mode_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(LONG_CYC);

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [MODE_W-1:0] mode_t;

    localparam cnt_t  DB_LAST   = cnt_t'(DEBOUNCE_CYC - 1);
    localparam cnt_t  LONG_LAST = cnt_t'(LONG_CYC - 1);
    localparam cnt_t  CNT_MAX   = '1;
    localparam mode_t MODE_LAST = mode_t'(NUM_MODES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPressDb,
        StHeld,
        StLongHeld,
        StRelDb
    } state_e;

    state_e state_q, state_d;
    logic   key_m_q, key_s_q;
    cnt_t   cnt_q, cnt_d, cnt_inc;
    logic   long_done_q, long_done_d;
    logic   level_q, level_d;
    logic   short_q, short_d;
    logic   long_q, long_d;
    logic   changed_q, changed_d;
    mode_t  mode_q, mode_d;

    // Counter saturates so it can never wrap back into a compare value.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + cnt_t'(1);

    // State register, synchronizer and all registered outputs.
    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            // Synchronizer resets to "released" so a key held through reset
            // is seen as a fresh press afterwards.
            key_m_q     <= 1'b1;
            key_s_q     <= 1'b1;
            state_q     <= StIdle;
            cnt_q       <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            changed_q   <= 1'b0;
            mode_q      <= '0;
        end else begin
            key_m_q     <= bus.KEY;
            key_s_q     <= key_m_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            short_q     <= short_d;
            long_q      <= long_d;
            changed_q   <= changed_d;
            mode_q      <= mode_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (!key_s_q) state_d = StPressDb;
            StPressDb: begin
                if (key_s_q)                 state_d = StIdle;
                else if (cnt_q == DB_LAST)   state_d = StHeld;
            end
            StHeld: begin
                if (key_s_q)                 state_d = StRelDb;
                else if (cnt_q == LONG_LAST) state_d = StLongHeld;
            end
            StLongHeld: if (key_s_q) state_d = StRelDb;
            // Release bounce keeps us here; the long timer never resumes.
            StRelDb:    if (key_s_q && (cnt_q == DB_LAST)) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Counter, level, mode and pulse next values.
    always_comb begin
        cnt_d       = cnt_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        short_d     = 1'b0;
        long_d      = 1'b0;
        changed_d   = 1'b0;
        mode_d      = mode_q;
        unique case (state_q)
            StIdle: begin
                if (!key_s_q) cnt_d = '0;
            end
            StPressDb: begin
                if (!key_s_q) begin
                    if (cnt_q == DB_LAST) begin
                        cnt_d   = '0;
                        level_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            StHeld: begin
                // Release wins over the long threshold on the same edge.
                if (key_s_q) begin
                    cnt_d       = '0;
                    long_done_d = 1'b0;
                end else if (cnt_q == LONG_LAST) begin
                    long_d    = 1'b1;
                    mode_d    = '0;
                    changed_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StLongHeld: begin
                if (key_s_q) begin
                    cnt_d       = '0;
                    long_done_d = 1'b1;
                end
            end
            StRelDb: begin
                if (!key_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_LAST) begin
                    cnt_d   = '0;
                    level_d = 1'b0;
                    if (!long_done_q) begin
                        short_d   = 1'b1;
                        changed_d = 1'b1;
                        mode_d    = (mode_q == MODE_LAST) ? '0 : mode_q + mode_t'(1);
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: ;
        endcase
    end

    assign bus.key_level    = level_q;
    assign bus.short_press  = short_q;
    assign bus.long_press   = long_q;
    assign bus.mode         = mode_q;
    assign bus.mode_changed = changed_q;

endmodule
